// File: rtl/dm_pkg.sv
// Shared types and defaults for the data-memory responder and its storage.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH_WORDS = 3072;
  localparam int DEFAULT_LATENCY     = 2;
  localparam int CNT_W               = 4;

endpackage

// File: rtl/dm_storage.sv
// Word-addressed data memory with per-byte write lanes, combinational read
// and a reset that clears every word.
module dm_storage #(
  parameter int DEPTH_WORDS = dm_pkg::DEFAULT_DEPTH_WORDS,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [3:0]       i_byteen,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] w_mask;

  assign w_mask = {{8{i_byteen[3]}}, {8{i_byteen[2]}}, {8{i_byteen[1]}}, {8{i_byteen[0]}}};

  // NOTE: this memory is deliberately reset, so it maps to flops rather than a
  // RAM macro; one process per word keeps the clear a plain per-register reset.
  for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_mem[g] <= '0;
      end else if (i_we && (i_idx == IDX_W'(g))) begin
        r_mem[g] <= (r_mem[g] & ~w_mask) | (i_wdata & w_mask);
      end
    end
  end

  assign o_rdata = (32'(i_idx) < 32'(DEPTH_WORDS)) ? r_mem[i_idx] : '0;

endmodule

// File: rtl/dm_responder.sv
// Single-outstanding data-memory responder: accepts one CPU request, waits
// LATENCY cycles, then presents a held response until the CPU takes it.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [29:0]        r_idx;
  logic [3:0]         r_byteen;
  logic [31:0]        r_wdata;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_rdata;
  logic               r_rsp_err;

  logic               w_accept;
  logic               w_from_idle;
  logic               w_we;
  logic [29:0]        w_idx;
  logic [3:0]         w_byteen;
  logic [31:0]        w_wdata;
  logic               w_in_range;
  logic               w_enter_resp;
  logic               w_mem_we;
  logic [31:0]        w_rdata;
  logic [31:0]        w_rsp_rdata;
  logic               w_unused;

  assign w_unused = ^req_addr[1:0];

  assign w_accept    = req_valid && r_req_ready;
  assign w_from_idle = (r_state == IDLE);

  // With zero latency the response is formed straight from the live request.
  assign w_we     = w_from_idle ? req_we         : r_we;
  assign w_idx    = w_from_idle ? req_addr[31:2] : r_idx;
  assign w_byteen = w_from_idle ? req_byteen     : r_byteen;
  assign w_wdata  = w_from_idle ? req_wdata      : r_wdata;

  assign w_in_range   = (32'(w_idx) < 32'(DEPTH_WORDS));
  assign w_enter_resp = (w_accept && (LATENCY == 0)) || ((r_state == WAIT) && (r_cnt == '0));
  assign w_mem_we     = w_enter_resp && w_we && w_in_range;
  assign w_rsp_rdata  = (!w_we && w_in_range) ? w_rdata : '0;

  dm_storage #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_storage (
    .clk      (clk),
    .reset    (reset),
    .i_we     (w_mem_we),
    .i_idx    (w_idx[IDX_W-1:0]),
    .i_byteen (w_byteen),
    .i_wdata  (w_wdata),
    .o_rdata  (w_rdata)
  );

  // NOTE: non-blocking updates mean a load captures the word as it was before
  // a store landing on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_idx       <= '0;
      r_byteen    <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we        <= req_we;
            r_idx       <= req_addr[31:2];
            r_byteen    <= req_byteen;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            if (LATENCY == 0) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rsp_rdata;
              r_rsp_err   <= !w_in_range;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= !w_in_range;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dm_responder.sv
// Randomised bench for dm_responder: a LATENCY=2 and a LATENCY=0 instance are
// checked against a word-array model built from the access rules.
module tb_dm_responder;

  localparam int DEPTH = 3072;
  localparam int LAT_A = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        req_valid_a, req_valid_b;
  logic        rr_a, rv_a, re_a, rr_b, rv_b, re_b;
  logic [31:0] rd_a, rd_b;
  logic        v_req_ready, v_rsp_valid, v_rsp_err;
  logic [31:0] v_rsp_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] mdl_mem [2][DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign req_valid_a = req_valid & ~sel;
  assign req_valid_b = req_valid & sel;
  assign v_req_ready = sel ? rr_b : rr_a;
  assign v_rsp_valid = sel ? rv_b : rv_a;
  assign v_rsp_rdata = sel ? rd_b : rd_a;
  assign v_rsp_err   = sel ? re_b : re_a;

  dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_a), .req_ready(rr_a), .req_we(req_we), .req_addr(req_addr),
    .req_byteen(req_byteen), .req_wdata(req_wdata),
    .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_rdata(rd_a), .rsp_err(re_a)
  );

  dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(rr_b), .req_we(req_we), .req_addr(req_addr),
    .req_byteen(req_byteen), .req_wdata(req_wdata),
    .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_rdata(rd_b), .rsp_err(re_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++) mdl_mem[d][w] = '0;
  endtask

  // One full transaction on the selected instance; called and returns at a negedge.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] o_rd, output int o_acc);
    int unsigned idx;
    int          d;
    int          edges;
    logic [31:0] exp_rd;
    logic        exp_err;
    d       = sel ? 1 : 0;
    idx     = addr[31:2];
    exp_err = (idx >= DEPTH);
    exp_rd  = '0;
    if (!exp_err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_rd = mdl_mem[d][idx];
      end
    end
    req_we = we; req_addr = addr; req_byteen = be; req_wdata = wd;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    edges = 0;
    while (!v_req_ready && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check("req_ready_before_accept", 32'(v_req_ready), 32'd1);
    @(negedge clk);
    o_acc     = cyc;
    req_valid = 1'b0;
    edges     = 1;
    while (!v_rsp_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("rsp_latency_edges", 32'(edges), sel ? 32'd1 : 32'(LAT_A + 1));
    check("rsp_rdata", v_rsp_rdata, exp_rd);
    check("rsp_err", 32'(v_rsp_err), 32'(exp_err));
    o_rd = v_rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(v_rsp_valid), 32'd1);
      check("hold_rsp_rdata", v_rsp_rdata, exp_rd);
      check("hold_req_ready", 32'(v_req_ready), 32'd0);
      // Stray store attempts to word 0 while busy must leave no trace.
      req_valid  = h[0];
      req_we     = 1'b1;
      req_addr   = 32'h0;
      req_byteen = 4'hF;
      req_wdata  = $urandom;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_hs_rsp_valid", 32'(v_rsp_valid), 32'd0);
    check("post_hs_req_ready", 32'(v_req_ready), 32'd1);
    rsp_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [29:0] w;
    case ($urandom_range(0, 9))
      0:       w = 30'd3071;
      1:       w = 30'(3072 + $urandom_range(0, 5));
      2:       w = 30'($urandom);
      default: w = 30'($urandom_range(0, 15));
    endcase
    return {w, 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    logic [31:0] rd;
    int          acc, prev;
    sel = 1'b0; reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = '0; req_byteen = '0; req_wdata = '0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_req_ready", 32'(rr_a), 32'd1);
    check("reset_rsp_valid", 32'(rv_a), 32'd0);
    check("reset_rsp_rdata", rd_a, 32'd0);
    check("reset_rsp_err", 32'(re_a), 32'd0);

    txn(1'b1, 32'h10, 4'b1111, 32'h1234_5678, 0, rd, acc);
    txn(1'b0, 32'h10, 4'b0000, 32'h0, 0, rd, acc);
    check("load_after_full_store", rd, 32'h1234_5678);
    txn(1'b1, 32'h10, 4'b0101, 32'hAABB_CCDD, 0, rd, acc);
    txn(1'b0, 32'h10, 4'b0000, 32'h0, 0, rd, acc);
    check("load_after_lane_store", rd, 32'h12BB_56DD);
    txn(1'b1, 32'h14, 4'b0000, 32'hFFFF_FFFF, 0, rd, acc);
    txn(1'b0, 32'h14, 4'b0000, 32'h0, 0, rd, acc);

    txn(1'b1, 32'h0000_0000, 4'b1111, 32'h0BAD_F00D, 0, rd, acc);
    txn(1'b1, 32'h0000_2FFC, 4'b1111, 32'hCAFE_BABE, 0, rd, acc);
    txn(1'b0, 32'h0000_3000, 4'b0000, 32'h0, 0, rd, acc);
    txn(1'b1, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF, 0, rd, acc);
    txn(1'b0, 32'h0000_0000, 4'b0000, 32'h0, 0, rd, acc);
    check("word0_after_oob_store", rd, 32'h0BAD_F00D);
    txn(1'b0, 32'h0000_2FFC, 4'b0000, 32'h0, 0, rd, acc);
    check("word3071_after_oob_store", rd, 32'hCAFE_BABE);

    txn(1'b0, 32'h10, 4'b0000, 32'h0, 5, rd, acc);
    txn(1'b0, 32'h0, 4'b0000, 32'h0, 0, rd, acc);

    // Reset while a store to 0x20 sits in WAIT.
    req_we = 1'b1; req_addr = 32'h20; req_byteen = 4'hF; req_wdata = 32'h5555_AAAA;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midwait_reset_req_ready", 32'(rr_a), 32'd1);
    check("midwait_reset_rsp_valid", 32'(rv_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    txn(1'b0, 32'h20, 4'b0000, 32'h0, 0, rd, acc);
    check("load_0x20_after_reset", rd, 32'd0);
    txn(1'b0, 32'h10, 4'b0000, 32'h0, 0, rd, acc);
    check("load_0x10_after_reset", rd, 32'd0);

    for (int i = 0; i < 80; i++) begin
      txn(1'($urandom_range(0, 1)), pick_addr(), 4'($urandom), $urandom,
          ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0, rd, acc);
    end

    sel  = 1'b1;
    prev = 0;
    for (int i = 0; i < 30; i++) begin
      txn(1'($urandom_range(0, 1)), pick_addr(), 4'($urandom), $urandom, 0, rd, acc);
      if (i > 0) check("b2b_accept_spacing", 32'(acc - prev), 32'd2);
      prev = acc;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 3072, meaning number of 32-bit data-memory words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles between request acceptance and response (legal range 0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  CPU request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port req_byteen  input  4  store byte-lane enables; bit i enables wdata[8i+7:8i].
REQ-010 SHALL have port req_wdata  input  32  store data.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  CPU accepts response.
REQ-013 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  address out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; one transaction outstanding at most.
REQ-016 SHALL drive req_ready=1 only in IDLE; accept when req_valid && req_ready at a rising edge, capturing we/addr/byteen/wdata.
REQ-017 On accept: LATENCY>0 -> WAIT with counter loaded LATENCY-1; LATENCY=0 -> RESP directly.
REQ-018 In WAIT: counter decrements each cycle; at 0 -> RESP next edge; rsp_valid first visible exactly LATENCY+1 edges after the accept edge.
REQ-019 On WAIT->RESP (or IDLE->RESP) edge: word index = addr[31:2]; index >= DEPTH_WORDS sets rsp_err=1, rsp_rdata=0, no memory write.
REQ-020 In-range store: write only lanes with byteen bit set, same edge; rsp_rdata=0; byteen=4'b0000 is a legal no-op still answered.
REQ-021 In-range load: rsp_rdata = full word at index, value sampled before any concurrent update.
REQ-022 In RESP: rsp_valid=1 and rsp_rdata/rsp_err held stable until rsp_valid && rsp_ready edge, then -> IDLE.
REQ-023 req_ready SHALL NOT rise in the same cycle as the response handshake; earliest next accept is the cycle after returning to IDLE.
REQ-024 req_valid while not ready SHALL be ignored with no side effect; requester holds it.

Reset
REQ-025 Asserting reset at any time, including mid-WAIT or mid-RESP, SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-026 Reset SHALL clear all memory words to 0; a store in flight at reset is discarded.

Structure
REQ-027 Shared package dm_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the default DEPTH_WORDS and LATENCY, and the counter width constant (4).
REQ-028 Storage SHALL be one sub-module dm_storage: byte-lane write-enabled word array with asynchronous read and reset clear; FSM/handshake stays in dm_responder.

Verification
REQ-029 Reset, store addr 0x0000_0010 data 0x1234_5678 byteen 1111, then load 0x10 -> rsp_rdata=0x1234_5678, rsp_err=0, rsp_valid 3 edges after each accept (LATENCY=2).
REQ-030 Store 0xAABB_CCDD byteen 0101 at 0x10 over 0x1234_5678 -> load returns 0x12BB_56DD.
REQ-031 Load addr 0x0000_3000 (index 3072) -> rsp_err=1, rsp_rdata=0; store there leaves word 0 and word 3071 unchanged.
REQ-032 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata stable; req_ready=0 throughout; req_valid pulses ignored.
REQ-033 Assert reset during WAIT of a store to 0x20 -> next cycle IDLE, rsp_valid=0; subsequent load 0x20 returns 0.
REQ-034 LATENCY=0 build, back-to-back requests with rsp_ready=1 -> rsp_valid one edge after accept, accepts spaced exactly 2 cycles apart.
